// File: rtl/cdc_hs_tx.sv
// cdc_hs_tx: source side of a 4-phase req/ack CDC handshake; optional phase timeout under CDC_HS_TIMEOUT_EN
module cdc_hs_tx #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              src_valid,
  input  logic [DATA_W-1:0] src_data,
  output logic              src_ready,
  output logic              xfer_req,
  output logic [DATA_W-1:0] xfer_data,
  input  logic              xfer_ack,
  output logic              done,
  output logic              busy,
  output logic              err,
  input  logic              err_clr
);
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DROP} state_t;
  state_t r_state, w_next;
  logic [SYNC_STAGES-1:0] r_sync;
  logic [DATA_W-1:0] r_data;
  logic r_req, r_done, r_err;
  logic w_ack_s, w_accept, w_to, w_req_d, w_done_d, w_tmo;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_sync <= '0;
    else r_sync <= {r_sync[SYNC_STAGES-2:0], xfer_ack};
  assign w_ack_s = r_sync[SYNC_STAGES-1];
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= S_IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = (r_state == S_IDLE) ? (w_accept ? S_REQ : S_IDLE)
           : (r_state == S_REQ)  ? (w_ack_s ? S_DROP : (w_to ? S_IDLE : S_REQ))
           : ((!w_ack_s || w_to) ? S_IDLE : S_DROP);
  end
  always_comb begin
    src_ready = (r_state == S_IDLE) && !w_ack_s;
    w_accept  = src_ready && src_valid;
    busy      = r_state != S_IDLE;
    w_req_d   = w_next == S_REQ;
    w_done_d  = (r_state == S_DROP) && !w_ack_s;
    w_tmo     = w_to && (w_next == S_IDLE) && !w_done_d;
  end
`ifdef CDC_HS_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] r_cnt;
  // restarts on every state change, so each phase gets its own budget
  always_ff @(posedge clk or posedge rst)
    if (rst) r_cnt <= '0;
    else r_cnt <= (w_next != r_state || r_state == S_IDLE) ? '0 : r_cnt + CNT_W'(1);
  assign w_to = (r_state != S_IDLE) && (r_cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
  assign w_to = 1'b0;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_req  <= 1'b0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
      r_data <= '0;
    end else begin
      r_req  <= w_req_d;
      r_done <= w_done_d;
      r_err  <= w_tmo | (r_err & ~err_clr);
      if (w_accept) r_data <= src_data;
    end
  assign xfer_req  = r_req;
  assign xfer_data = r_data;
  assign done      = r_done;
  assign err       = r_err;
endmodule
